// File: rtl/cnt_ctrl_pkg.sv
// Shared encodings for the cnt_ctrl run-control sequencer.
package cnt_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

endpackage

// File: rtl/cnt_prescaler.sv
// Clock-enable prescaler: counts 0..DIV-1 while enabled, strobes wrap_c on the last phase.
module cnt_prescaler #(
  parameter int unsigned DIV = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic wrap_c
);

  localparam int unsigned PW = $clog2(DIV);

  logic [PW-1:0] r_cnt;

  assign wrap_c = en && (r_cnt == PW'(DIV - 1));

  // clr has priority so a CLEAR landing on a wrap edge restarts the phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (wrap_c) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + PW'(1);
    end
  end

endmodule

// File: rtl/cnt_ctrl.sv
// Run-control sequencer for the mod-N event counter; one-shot START mode
// is built in when CNT_CTRL_ONESHOT_EN is defined.
module cnt_ctrl
  import cnt_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned DIV         = 5,
  parameter int unsigned DEFAULT_MOD = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             cmd_err,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc,
  output logic [1:0]       state
);

`ifdef CNT_CTRL_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_count, w_count_nxt;
  logic [WIDTH-1:0] r_mod, w_mod_nxt;
  logic             r_tick, w_tick_nxt;
  logic             r_tc, w_tc_nxt;
  logic             r_err, w_err_nxt;
  logic             r_ready, w_ready_nxt;
  logic             r_oneshot, w_oneshot_nxt;

  logic w_accept, w_wrap, w_last, w_psc_en, w_psc_clr;

  assign w_accept  = cmd_valid && r_ready;
  assign w_psc_en  = (r_state == RUN);
  assign w_psc_clr = w_accept && ((cmd_op == OP_CLEAR) ||
                                  ((cmd_op == OP_STOP) && (r_state == PAUSE)));
  // mod==0 wraps naturally to all-ones, giving a full 2^WIDTH cycle
  assign w_last    = (r_count == (r_mod - WIDTH'(1)));

  cnt_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en     (w_psc_en),
    .clr    (w_psc_clr),
    .wrap_c (w_wrap)
  );

  // Next-state: the counter advance is applied first, then commands override it
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_mod_nxt     = r_mod;
    w_tick_nxt    = 1'b0;
    w_tc_nxt      = 1'b0;
    w_err_nxt     = 1'b0;
    w_ready_nxt   = !w_accept;
    w_oneshot_nxt = r_oneshot;

    if (w_wrap) begin
      w_tick_nxt  = 1'b1;
      w_tc_nxt    = w_last;
      w_count_nxt = w_last ? '0 : (r_count + WIDTH'(1));
      if (r_oneshot && w_last) begin
        w_state_nxt = IDLE;
      end
    end

    if (w_accept) begin
      case (cmd_op)
        OP_START: begin
          if (r_state != RUN) begin
            w_state_nxt   = RUN;
            w_oneshot_nxt = ONESHOT && cmd_data[0];
          end
        end
        OP_STOP: begin
          w_oneshot_nxt = 1'b0;
          if (r_state == RUN) begin
            w_state_nxt = PAUSE;
          end else if (r_state == PAUSE) begin
            w_state_nxt = IDLE;
          end
        end
        OP_CLEAR: begin
          w_count_nxt = '0;
          w_tick_nxt  = 1'b0;
          w_tc_nxt    = 1'b0;
          w_state_nxt = r_state;
        end
        OP_LOAD: begin
          if (r_state == RUN) begin
            w_err_nxt = 1'b1;
          end else begin
            w_mod_nxt   = cmd_data;
            w_count_nxt = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_mod     <= WIDTH'(DEFAULT_MOD);
      r_tick    <= 1'b0;
      r_tc      <= 1'b0;
      r_err     <= 1'b0;
      r_ready   <= 1'b1;
      r_oneshot <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_mod     <= w_mod_nxt;
      r_tick    <= w_tick_nxt;
      r_tc      <= w_tc_nxt;
      r_err     <= w_err_nxt;
      r_ready   <= w_ready_nxt;
      r_oneshot <= w_oneshot_nxt;
    end
  end

  assign cmd_ready = r_ready;
  assign cmd_err   = r_err;
  assign count     = r_count;
  assign tick      = r_tick;
  assign tc        = r_tc;
  assign state     = r_state;

endmodule

// File: tb/tb_cnt_ctrl.sv
// Scoreboard bench for cnt_ctrl (WIDTH=4, DIV=5); honours CNT_CTRL_ONESHOT_EN.
module tb_cnt_ctrl;
  import cnt_ctrl_pkg::*;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DIV   = 5;

`ifdef CNT_CTRL_ONESHOT_EN
  localparam bit ONESHOT_TB = 1'b1;
`else
  localparam bit ONESHOT_TB = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_err;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             tc;
  logic [1:0]       state;

  int n_vec = 0;
  int n_err = 0;

  cnt_ctrl #(
    .WIDTH       (WIDTH),
    .DIV         (DIV),
    .DEFAULT_MOD (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_err   (cmd_err),
    .count     (count),
    .tick      (tick),
    .tc        (tc),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model of the expected outputs after each clock edge
  typedef struct packed {
    state_t     st;
    logic [3:0] cnt;
    logic [3:0] mod;
    logic [2:0] psc;
    logic       os;
    logic       rdy;
    logic       tk;
    logic       tc;
    logic       err;
  } mdl_t;

  localparam mdl_t M_RST = '{st: IDLE, cnt: 4'd0, mod: 4'd10, psc: 3'd0, os: 1'b0,
                             rdy: 1'b1, tk: 1'b0, tc: 1'b0, err: 1'b0};

  function automatic mdl_t step(input mdl_t s, input logic v, input logic [1:0] op,
                                input logic [3:0] d);
    mdl_t n;
    int   eff;
    logic acc;
    n     = s;
    n.tk  = 1'b0;
    n.tc  = 1'b0;
    n.err = 1'b0;
    acc   = v && s.rdy;
    n.rdy = !acc;
    eff   = (s.mod == 4'd0) ? 16 : int'(s.mod);
    if (s.st == RUN) begin
      if (int'(s.psc) == int'(DIV) - 1) begin
        n.psc = 3'd0;
        n.tk  = 1'b1;
        if (int'(s.cnt) == eff - 1) begin
          n.cnt = 4'd0;
          n.tc  = 1'b1;
          if (s.os) n.st = IDLE;
        end else begin
          n.cnt = s.cnt + 4'd1;
        end
      end else begin
        n.psc = s.psc + 3'd1;
      end
    end
    if (acc) begin
      case (op)
        OP_START: if (s.st != RUN) begin
          n.st = RUN;
          n.os = ONESHOT_TB & d[0];
        end
        OP_STOP: begin
          n.os = 1'b0;
          if (s.st == RUN) n.st = PAUSE;
          else if (s.st == PAUSE) begin
            n.st  = IDLE;
            n.psc = 3'd0;
          end
        end
        OP_CLEAR: begin
          n.cnt = 4'd0;
          n.psc = 3'd0;
          n.tk  = 1'b0;
          n.tc  = 1'b0;
          n.st  = s.st;
        end
        default: begin
          if (s.st == RUN) n.err = 1'b1;
          else begin
            n.mod = d;
            n.cnt = 4'd0;
          end
        end
      endcase
    end
    return n;
  endfunction

  mdl_t m;
  mdl_t e;
  mdl_t q[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m <= M_RST;
      q.delete();
    end else begin
      q.push_back(step(m, cmd_valid, cmd_op, cmd_data));
      m <= step(m, cmd_valid, cmd_op, cmd_data);
    end
  end

  always @(negedge clk) begin
    if (rst && (q.size() != 0)) begin
      e = q.pop_front();
      check_eq("sb_state", 32'(state), 32'(e.st));
      check_eq("sb_count", 32'(count), 32'(e.cnt));
      check_eq("sb_tick", 32'(tick), 32'(e.tk));
      check_eq("sb_tc", 32'(tc), 32'(e.tc));
      check_eq("sb_err", 32'(cmd_err), 32'(e.err));
      check_eq("sb_ready", 32'(cmd_ready), 32'(e.rdy));
    end
  end

  // Drive one command from a negedge; returns at the negedge after the accept edge
  task automatic send_cmd(input logic [1:0] op, input logic [3:0] d);
    bit done;
    done      = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    for (int i = 0; i < 4 && !done; i++) begin
      if (cmd_ready) begin
        @(posedge clk);
        @(negedge clk);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    cmd_valid = 1'b0;
    if (!done) check_eq("accept_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_tick(input int limit, output logic [3:0] prev, output logic got_tc);
    logic [3:0] last;
    last   = count;
    prev   = last;
    got_tc = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (tick) begin
        prev   = last;
        got_tc = tc;
        return;
      end
      last = count;
    end
    check_eq("tick_timeout", 32'(0), 32'(1));
  endtask

  logic [3:0] prev;
  logic       gtc;
  int         nticks;

  initial begin
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 4'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_state", 32'(state), 32'(0));
    check_eq("rst_ready", 32'(cmd_ready), 32'(1));
    check_eq("rst_count", 32'(count), 32'(0));
    check_eq("rst_tick", 32'(tick), 32'(0));
    check_eq("rst_tc", 32'(tc), 32'(0));
    check_eq("rst_err", 32'(cmd_err), 32'(0));
    rst = 1'b1;
    @(negedge clk);

    // Basic run: first tick 5 cycles after START, tc on the 10th tick
    send_cmd(OP_LOAD, 4'd10);
    send_cmd(OP_START, 4'd0);
    repeat (4) @(negedge clk);
    check_eq("first_tick_early", 32'(tick), 32'(0));
    @(negedge clk);
    check_eq("first_tick", 32'(tick), 32'(1));
    check_eq("first_count", 32'(count), 32'(1));
    repeat (44) @(negedge clk);
    check_eq("count_before_wrap", 32'(count), 32'(9));
    @(negedge clk);
    check_eq("wrap_tc", 32'(tc), 32'(1));
    check_eq("wrap_count", 32'(count), 32'(0));

    // Pause with prescaler at 2, count 3
    repeat (17) @(negedge clk);
    check_eq("pre_stop_count", 32'(count), 32'(3));
    send_cmd(OP_STOP, 4'd0);
    check_eq("pause_state", 32'(state), 32'(PAUSE));
    repeat (20) @(negedge clk);
    check_eq("pause_hold", 32'(count), 32'(3));
    send_cmd(OP_START, 4'd0);
    @(negedge clk);
    check_eq("resume_early", 32'(tick), 32'(0));
    @(negedge clk);
    check_eq("resume_tick", 32'(tick), 32'(1));
    check_eq("resume_count", 32'(count), 32'(4));

    // LOAD while running is rejected
    send_cmd(OP_LOAD, 4'd7);
    check_eq("load_err", 32'(cmd_err), 32'(1));
    @(negedge clk);
    check_eq("load_err_pulse", 32'(cmd_err), 32'(0));
    for (int i = 0; i < 12; i++) begin
      wait_tick(20, prev, gtc);
      if (gtc) break;
    end
    check_eq("mod_kept", 32'(prev), 32'(9));

    // Modulus 0: full 16-state wrap
    send_cmd(OP_STOP, 4'd0);
    send_cmd(OP_STOP, 4'd0);
    check_eq("stop_idle", 32'(state), 32'(IDLE));
    send_cmd(OP_LOAD, 4'd0);
    send_cmd(OP_START, 4'd0);
    nticks = 0;
    for (int i = 0; i < 20; i++) begin
      wait_tick(20, prev, gtc);
      nticks++;
      if (gtc) break;
    end
    check_eq("mod0_prev", 32'(prev), 32'(15));
    check_eq("mod0_ticks", 32'(nticks), 32'(16));

    // Modulus 1: tc on every tick
    send_cmd(OP_STOP, 4'd0);
    send_cmd(OP_STOP, 4'd0);
    send_cmd(OP_LOAD, 4'd1);
    send_cmd(OP_START, 4'd0);
    for (int i = 0; i < 3; i++) begin
      wait_tick(20, prev, gtc);
      check_eq("mod1_tc", 32'(gtc), 32'(1));
      check_eq("mod1_count", 32'(count), 32'(0));
    end

    // CLEAR accepted on a tick edge wins
    send_cmd(OP_STOP, 4'd0);
    send_cmd(OP_STOP, 4'd0);
    send_cmd(OP_LOAD, 4'd10);
    send_cmd(OP_START, 4'd0);
    repeat (14) @(negedge clk);
    check_eq("pre_clear_count", 32'(count), 32'(2));
    send_cmd(OP_CLEAR, 4'd0);
    check_eq("clr_tick", 32'(tick), 32'(0));
    check_eq("clr_tc", 32'(tc), 32'(0));
    check_eq("clr_count", 32'(count), 32'(0));
    repeat (5) @(negedge clk);
    check_eq("post_clr_tick", 32'(tick), 32'(1));
    check_eq("post_clr_count", 32'(count), 32'(1));

    // Asynchronous reset in the middle of a cycle
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_state", 32'(state), 32'(IDLE));
    check_eq("arst_count", 32'(count), 32'(0));
    check_eq("arst_ready", 32'(cmd_ready), 32'(1));
    check_eq("arst_tick", 32'(tick), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

`ifdef CNT_CTRL_ONESHOT_EN
    send_cmd(OP_LOAD, 4'd3);
    send_cmd(OP_START, 4'd1);
    for (int i = 0; i < 3; i++) begin
      wait_tick(20, prev, gtc);
      check_eq("os_tc", 32'(gtc), 32'(i == 2));
    end
    check_eq("os_idle", 32'(state), 32'(IDLE));
    repeat (20) @(negedge clk);
    check_eq("os_stay_idle", 32'(state), 32'(IDLE));
    check_eq("os_count", 32'(count), 32'(0));
`endif

    // Random command traffic, checked by the scoreboard
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 15)) @(negedge clk);
      send_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
